// File: rtl/request_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : request_dispatcher
// Purpose  : Downstream stage of the scheduler. A one-cycle enable/id grant
//            pops the head word of the granted queue. The word is forwarded on
//            a valid/ready master channel, and a one-cycle consumed pulse
//            closes the transaction. Only one transaction is in flight at a
//            time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   single clock, all state on posedge
//   reset        in   asynchronous, active-low reset
//   enable       in   grant pulse from the scheduler (1 cycle)
//   id           in   granted queue index, valid with enable
//   empty        in   per-queue empty flags
//   lastElem     in   per-queue head-is-last-element flags
//   heads        in   per-queue head word (first-word-fall-through)
//   pop          out  one-hot, 1-cycle pop strobe to the queues
//   m_valid      out  master request valid
//   m_ready      in   master request ready
//   m_data       out  forwarded request word
//   m_id         out  source queue of m_data
//   m_last       out  lastElem of the source queue at pop time
//   consumed     out  1-cycle completion pulse to the scheduler
//   clear_stats  in   (DISPATCH_STATS_EN) synchronous clear of the counters
//   sent_count   out  (DISPATCH_STATS_EN) per-queue handshake count
//   drop_count   out  (DISPATCH_STATS_EN) count of dropped grants
// Configuration
//   DISPATCH_STATS_EN : when defined, adds the saturating statistics
//                       counters and their ports. The FSM is the same
//                       either way.
// ============================================================================
module request_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REQUEST_SIZE     = 64,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]              id,
  input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
  input  logic [NUMBER_OF_QUEUES-1:0]                      lastElem,
  input  logic [NUMBER_OF_QUEUES-1:0][REQUEST_SIZE-1:0]    heads,
  output logic [NUMBER_OF_QUEUES-1:0]                      pop,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic [REQUEST_SIZE-1:0]                          m_data,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              m_id,
  output logic                                             m_last,
  output logic                                             consumed
`ifdef DISPATCH_STATS_EN
  ,
  input  logic                                             clear_stats,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   sent_count,
  output logic [REGISTER_SIZE-1:0]                         drop_count
`endif
);

  localparam int c_id_w = $clog2(NUMBER_OF_QUEUES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [c_id_w-1:0]         id_q, id_d;
  logic [REQUEST_SIZE-1:0]   m_data_q, m_data_d;
  logic [c_id_w-1:0]         m_id_q, m_id_d;
  logic                      m_last_q, m_last_d;
  logic [NUMBER_OF_QUEUES-1:0] pop_w;
  logic                      id_in_range;
  logic                      pop_ok;

  // A power-of-two queue count cannot produce an out-of-range index, so the
  // range compare is only built when some id codes are unused.
  generate
    if ((1 << c_id_w) == NUMBER_OF_QUEUES) begin : g_id_pow2
      assign id_in_range = 1'b1;
    end else begin : g_id_range
      assign id_in_range = (int'(id_q) < NUMBER_OF_QUEUES);
    end
  endgenerate

  // The granted queue can be served only if it exists and has a head word.
  assign pop_ok = id_in_range && !empty[id_q];

  // --------------------------------------------------------------------------
  // FSM: next state and datapath capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    m_data_d = m_data_q;
    m_id_d   = m_id_q;
    m_last_d = m_last_q;
    pop_w    = '0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          id_d    = id;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        if (pop_ok) begin
          pop_w[id_q] = 1'b1;
          m_data_d    = heads[id_q];
          m_last_d    = lastElem[id_q];
          m_id_d      = id_q;
          state_d     = ST_SEND;
        end else begin
          // Drop: nothing to forward, but the scheduler still needs its
          // consumed pulse to close the transaction.
          state_d = ST_DONE;
        end
      end

      ST_SEND: begin
        if (m_ready) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      m_data_q <= '0;
      m_id_q   <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      m_data_q <= m_data_d;
      m_id_q   <= m_id_d;
      m_last_q <= m_last_d;
    end
  end

  // m_valid and consumed decode the state register only, so there is no
  // combinational path from any input, and an asynchronous reset drops both
  // immediately.
  assign pop      = pop_w;
  assign m_valid  = (state_q == ST_SEND);
  assign consumed = (state_q == ST_DONE);
  assign m_data   = m_data_q;
  assign m_id     = m_id_q;
  assign m_last   = m_last_q;

`ifdef DISPATCH_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  localparam logic [REGISTER_SIZE-1:0] c_cnt_one = REGISTER_SIZE'(1);

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] sent_q, sent_d;
  logic [REGISTER_SIZE-1:0]                       drop_q, drop_d;
  logic                                           handshake;
  logic                                           drop;

  assign handshake = (state_q == ST_SEND) && m_ready;
  assign drop      = (state_q == ST_POP) && !pop_ok;

  always_comb begin
    sent_d = sent_q;
    drop_d = drop_q;
    // A clear overrides any increment that lands in the same cycle.
    if (clear_stats) begin
      sent_d = '0;
      drop_d = '0;
    end else begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (handshake && (int'(m_id_q) == q) && (sent_q[q] != '1)) begin
          sent_d[q] = sent_q[q] + c_cnt_one;
        end
      end
      if (drop && (drop_q != '1)) begin
        drop_d = drop_q + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      sent_q <= sent_d;
      drop_q <= drop_d;
    end
  end

  assign sent_count = sent_q;
  assign drop_count = drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_request_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_request_dispatcher
// Purpose  : Scoreboard testbench for request_dispatcher. Stimulus pushes the
//            expected pop strobe and forwarded word. A monitor pops the
//            expected values and compares them at each pop and each
//            handshake. Directed checks cover latency, back-pressure, drops,
//            ignored enables and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_dispatcher;

  localparam int NQ = 4;
  localparam int RS = 64;
`ifdef DISPATCH_STATS_EN
  // A narrow counter makes saturation reachable with a handful of sends.
  localparam int RG = 2;
`else
  localparam int RG = 32;
`endif

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic                     enable = 1'b0;
  logic [1:0]               id = 2'd0;
  logic [NQ-1:0]            empty = '1;
  logic [NQ-1:0]            last_elem = '0;
  logic [NQ-1:0][RS-1:0]    heads = '0;
  logic [NQ-1:0]            pop;
  logic                     m_valid;
  logic                     m_ready = 1'b1;
  logic [RS-1:0]            m_data;
  logic [1:0]               m_id;
  logic                     m_last;
  logic                     consumed;
`ifdef DISPATCH_STATS_EN
  logic                     clear_stats = 1'b0;
  logic [NQ-1:0][RG-1:0]    sent_count;
  logic [RG-1:0]            drop_count;
`endif

  request_dispatcher #(
    .NUMBER_OF_QUEUES(NQ),
    .REQUEST_SIZE(RS),
    .REGISTER_SIZE(RG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .id(id),
    .empty(empty),
    .lastElem(last_elem),
    .heads(heads),
    .pop(pop),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_id(m_id),
    .m_last(m_last),
    .consumed(consumed)
`ifdef DISPATCH_STATS_EN
    ,
    .clear_stats(clear_stats),
    .sent_count(sent_count),
    .drop_count(drop_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [RS-1:0] data;
    logic [1:0]    qid;
    logic          last;
  } txn_t;

  txn_t          exp_q[$];
  logic [NQ-1:0] pop_exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            pop_seen = 0;
  int            cons_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every pop strobe and every handshake with the queue head.
  always @(negedge clock) begin
    txn_t e;
    if (reset) begin
      if (pop !== '0) begin
        pop_seen++;
        if (pop_exp_q.size() == 0) check("unexpected_pop", 64'(pop), 64'd0);
        else                       check("sb_pop", 64'(pop), 64'(pop_exp_q.pop_front()));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 64'(m_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", m_data, e.data);
          check("sb_id",   64'(m_id), 64'(e.qid));
          check("sb_last", 64'(m_last), 64'(e.last));
        end
      end
      if (consumed) cons_seen++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a grant. The expected response comes from the queue state presented.
  task automatic grant(input logic [1:0] q);
    txn_t t;
    enable = 1'b1;
    id     = q;
    if (!empty[q]) begin
      t.data = heads[q];
      t.qid  = q;
      t.last = last_elem[q];
      exp_q.push_back(t);
      pop_exp_q.push_back(NQ'(1) << q);
    end
    tick();
    enable = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] q);
    grant(q);
    tick();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int p0, c0, vcount;

    // ---------------- reset state ----------------
    #12;
    check("rst_m_valid",  64'(m_valid), 64'd0);
    check("rst_pop",      64'(pop), 64'd0);
    check("rst_consumed", 64'(consumed), 64'd0);
    check("rst_m_data",   m_data, 64'd0);
    check("rst_m_id",     64'(m_id), 64'd0);
    check("rst_m_last",   64'(m_last), 64'd0);
    #10 reset = 1'b1;
    tick();

    // ---------------- 1: basic grant, exact latency ----------------
    empty     = 4'b1011;
    heads[2]  = 64'hA5;
    last_elem = 4'b0100;
    m_ready   = 1'b1;
    grant(2'd2);
    check("t1_pop",        64'(pop), 64'h4);
    check("t1_pop_valid",  64'(m_valid), 64'd0);
    tick();
    check("t1_valid",      64'(m_valid), 64'd1);
    check("t1_data",       m_data, 64'hA5);
    check("t1_id",         64'(m_id), 64'd2);
    check("t1_last",       64'(m_last), 64'd1);
    check("t1_no_cons",    64'(consumed), 64'd0);
    tick();
    check("t1_consumed",   64'(consumed), 64'd1);
    check("t1_valid_drop", 64'(m_valid), 64'd0);
    tick();
    check("t1_cons_pulse", 64'(consumed), 64'd0);

    // ---------------- 2: back-pressure ----------------
    empty     = 4'b1101;
    heads[1]  = 64'h0123_4567_89AB_CDEF;
    last_elem = 4'b0000;
    m_ready   = 1'b0;
    p0        = pop_seen;
    grant(2'd1);
    tick();
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid && m_data == 64'h0123_4567_89AB_CDEF) vcount++;
      tick();
    end
    m_ready = 1'b1;
    if (m_valid && m_data == 64'h0123_4567_89AB_CDEF) vcount++;
    check("t2_valid_cycles", 64'(vcount), 64'd6);
    tick();
    check("t2_consumed",   64'(consumed), 64'd1);
    check("t2_single_pop", 64'(pop_seen - p0), 64'd1);
    tick();

    // ---------------- 3: empty grant is dropped ----------------
    empty = 4'b1111;
    p0    = pop_seen;
    grant(2'd1);
    check("t3_no_pop",   64'(pop), 64'd0);
    tick();
    check("t3_consumed", 64'(consumed), 64'd1);
    check("t3_no_valid", 64'(m_valid), 64'd0);
    tick();
    check("t3_pop_count", 64'(pop_seen - p0), 64'd0);
`ifdef DISPATCH_STATS_EN
    check("t3_drop_count", 64'(drop_count), 64'd1);
`endif

    // ---------------- 4: spurious enable during SEND ----------------
    empty     = 4'b0110;
    heads[3]  = 64'hDEAD_BEEF_0000_0003;
    heads[0]  = 64'h0000_0000_0000_0C00;
    last_elem = 4'b1000;
    m_ready   = 1'b0;
    p0        = pop_seen;
    c0        = cons_seen;
    grant(2'd3);
    tick();
    enable = 1'b1;
    id     = 2'd0;
    tick();
    enable = 1'b0;
    tick();
    check("t4_still_send", 64'(m_valid), 64'd1);
    check("t4_id_held",    64'(m_id), 64'd3);
    m_ready = 1'b1;
    tick();
    check("t4_consumed", 64'(consumed), 64'd1);
    tick();
    check("t4_one_pop",  64'(pop_seen - p0), 64'd1);
    check("t4_one_cons", 64'(cons_seen - c0), 64'd1);
    run_txn(2'd0);
    check("t4_next_served", 64'(pop_seen - p0), 64'd2);

    // ---------------- 5: asynchronous reset mid-SEND ----------------
    empty     = 4'b1110;
    heads[0]  = 64'h5555;
    last_elem = 4'b0000;
    m_ready   = 1'b0;
    grant(2'd0);
    tick();
    check("t5_in_send", 64'(m_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_valid",    64'(m_valid), 64'd0);
    check("t5_rst_consumed", 64'(consumed), 64'd0);
    check("t5_rst_data",     m_data, 64'd0);
    exp_q.delete();
    tick();
    #2 reset = 1'b1;
    heads[0]  = 64'h0F0F;
    last_elem = 4'b0001;
    m_ready   = 1'b1;
    tick();
    grant(2'd0);
    tick();
    check("t5_data_after", m_data, 64'h0F0F);
    tick();
    check("t5_consumed", 64'(consumed), 64'd1);
    tick();

`ifdef DISPATCH_STATS_EN
    // ---------------- 6: statistics ----------------
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("t6_cleared", 64'(sent_count), 64'd0);
    empty    = 4'b0110;
    heads[0] = 64'h10;
    heads[3] = 64'h13;
    last_elem = 4'b0000;
    m_ready  = 1'b1;
    run_txn(2'd0);
    run_txn(2'd0);
    run_txn(2'd0);
    run_txn(2'd3);
    check("t6_sent", 64'(sent_count), 64'({2'd1, 2'd0, 2'd0, 2'd3}));
    run_txn(2'd0);
    check("t6_saturate", 64'(sent_count[0]), 64'd3);
    empty    = 4'b0100;
    heads[1] = 64'h11;
    grant(2'd1);
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("t6_clear_prio_sent", 64'(sent_count), 64'd0);
    check("t6_clear_prio_drop", 64'(drop_count), 64'd0);
    tick();
`endif

    tick();
    check("sb_drained",     64'(exp_q.size()), 64'd0);
    check("sb_pop_drained", 64'(pop_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
